aes_round_sequencer: RTL and testbench

- Control block for one AES-128 encryption pass.
- Accepts a 128-bit plaintext through a valid/ready handshake and owns the working state register.
- Issues a fixed schedule of 40 round operations to a shared round-operation unit (SubBytes, ShiftRows, MixColumns, AddRoundKey) using a start/finish handshake, and drives that unit's round number.
- Returns the ciphertext through a valid/ready handshake, with a watchdog that flags a step unit that never finishes.

---
 rtl/aes_pkg.sv | 23 ++
 rtl/aes_round_sequencer_if.sv | 32 +++
 rtl/aes_op_schedule.sv | 34 +++
 rtl/aes_round_sequencer.sv | 114 +++++++++++
 tb/tb_aes_round_sequencer.sv | 347 ++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/aes_pkg.sv
// Shared AES-128 sequencer types: block width, round count, op codes, FSM encoding.
// No logic; pure declarations.
// Imported by the sequencer, its schedule sub-module and the bus interface.
package aes_pkg;
    localparam int BLOCK_W           = 128;
    localparam int NUM_ROUNDS_AES128 = 10;

    // Operation codes understood by the shared round-operation unit.
    typedef enum logic [1:0] {
        ADDKEY    = 2'd0,
        SUBBYTES  = 2'd1,
        SHIFTROWS = 2'd2,
        MIXCOLS   = 2'd3
    } op_t;

    // Sequencer FSM states.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        DONE  = 2'd3
    } seq_state_t;
endpackage

// File: rtl/aes_round_sequencer_if.sv
// Bundles the plaintext/ciphertext handshakes and the round-unit start/finish bus.
// Wires only, no latency.
// master = sequencer side, slave = surrounding datapath (or bench).
interface aes_round_sequencer_if;
    import aes_pkg::*;

    logic               in_valid;
    logic               in_ready;
    logic [BLOCK_W-1:0] in_block;
    logic               out_valid;
    logic               out_ready;
    logic [BLOCK_W-1:0] out_block;
    logic               out_err;
    logic               step_start;
    op_t                step_op;
    logic [3:0]         step_round;
    logic [BLOCK_W-1:0] step_state;
    logic [BLOCK_W-1:0] step_result;
    logic               step_finish;

    modport master (
        input  in_valid, in_block, out_ready, step_result, step_finish,
        output in_ready, out_valid, out_block, out_err,
               step_start, step_op, step_round, step_state
    );

    modport slave (
        output in_valid, in_block, out_ready, step_result, step_finish,
        input  in_ready, out_valid, out_block, out_err,
               step_start, step_op, step_round, step_state
    );
endinterface

// File: rtl/aes_op_schedule.sv
// Maps the current (op, round) to the following schedule entry and flags the final op.
// Purely combinational, zero latency.
// No handshake; the sequencer decides when to advance.
module aes_op_schedule
    import aes_pkg::*;
#(
    parameter int NUM_ROUNDS = NUM_ROUNDS_AES128
) (
    input  op_t        op,
    input  logic [3:0] round,
    output op_t        next_op,
    output logic [3:0] next_round,
    output logic       is_last
);
    localparam logic [3:0] LAST_ROUND = 4'(NUM_ROUNDS);

    // Round 0 is a lone ADDKEY; the final round skips MIXCOLS; only ADDKEY bumps the round.
    always_comb begin
        next_op    = ADDKEY;
        next_round = round;
        is_last    = 1'b0;
        case (op)
            ADDKEY: begin
                next_op    = SUBBYTES;
                next_round = round + 4'd1;
                is_last    = (round == LAST_ROUND);
            end
            SUBBYTES:  next_op = SHIFTROWS;
            SHIFTROWS: next_op = (round == LAST_ROUND) ? ADDKEY : MIXCOLS;
            MIXCOLS:   next_op = ADDKEY;
            default:   next_op = ADDKEY;
        endcase
    end
endmodule

// File: rtl/aes_round_sequencer.sv
// Runs one AES-128 encryption pass by issuing the fixed op schedule to a shared round unit.
// Latency: 1 + 2 cycles per op (81 with an immediately-finishing unit) plus unit wait cycles.
// Backpressure: in_ready only in IDLE; result held until out_ready; watchdog aborts a stuck unit.
module aes_round_sequencer
    import aes_pkg::*;
#(
    parameter int NUM_ROUNDS     = NUM_ROUNDS_AES128,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                  clk,
    input  logic                  rst,
    output logic                  busy,
    aes_round_sequencer_if.master bus
);
    // The counter never has to hold more than TIMEOUT_CYCLES-1.
    localparam int               CNT_W     = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LIMIT = CNT_W'(TIMEOUT_CYCLES - 1);

    seq_state_t         state_q, state_d;
    logic [BLOCK_W-1:0] blk_q, blk_d;
    op_t                op_q, op_d, next_op;
    logic [3:0]         round_q, round_d, next_round;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               err_q, err_d;
    logic               is_last;

    aes_op_schedule #(.NUM_ROUNDS(NUM_ROUNDS)) u_sched (
        .op         (op_q),
        .round      (round_q),
        .next_op    (next_op),
        .next_round (next_round),
        .is_last    (is_last)
    );

    // State register, working block, schedule position, watchdog and error flag.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            blk_q   <= '0;
            op_q    <= ADDKEY;
            round_q <= '0;
            cnt_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            blk_q   <= blk_d;
            op_q    <= op_d;
            round_q <= round_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
        end
    end

    // Next-state logic; every register holds unless a state below changes it.
    always_comb begin
        state_d = state_q;
        blk_d   = blk_q;
        op_d    = op_q;
        round_d = round_q;
        cnt_d   = cnt_q;
        err_d   = err_q;
        case (state_q)
            IDLE: begin
                if (bus.in_valid) begin
                    blk_d   = bus.in_block;
                    op_d    = ADDKEY;
                    round_d = '0;
                    err_d   = 1'b0;
                    state_d = ISSUE;
                end
            end
            ISSUE: begin
                cnt_d   = '0;
                state_d = WAIT;
            end
            WAIT: begin
                // A finish on the watchdog's final cycle still counts as success.
                if (bus.step_finish) begin
                    blk_d = bus.step_result;
                    if (is_last) begin
                        state_d = DONE;
                    end else begin
                        op_d    = next_op;
                        round_d = next_round;
                        state_d = ISSUE;
                    end
                end else if (cnt_q == CNT_LIMIT) begin
                    err_d   = 1'b1;
                    state_d = DONE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            DONE: begin
                if (bus.out_ready) begin
                    err_d   = 1'b0;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // All outputs come straight from registers so reset takes effect immediately.
    assign bus.in_ready   = (state_q == IDLE);
    assign bus.out_valid  = (state_q == DONE);
    assign bus.out_block  = blk_q;
    assign bus.out_err    = err_q;
    assign bus.step_start = (state_q == ISSUE);
    assign bus.step_op    = op_q;
    assign bus.step_round = round_q;
    assign bus.step_state = blk_q;
    assign busy           = (state_q != IDLE);
endmodule

// File: tb/tb_aes_round_sequencer.sv
// Randomized bench for aes_round_sequencer against a schedule-level reference model.
// Stub round unit: XOR pattern or real AES-128 ops, with per-op finish delay or withholding.
// Covers reset, latency, FIPS-197 C.1, watchdog abort, late finish, backpressure, mid-pass reset.
module tb_aes_round_sequencer;
    logic clk = 1'b0;
    logic rst = 1'b0;
    logic busy;

    aes_round_sequencer_if bus();

    aes_round_sequencer #(.NUM_ROUNDS(10), .TIMEOUT_CYCLES(4)) dut (
        .clk  (clk),
        .rst  (rst),
        .busy (busy),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    // Stub / model controls
    bit         aes_mode     = 1'b0;
    bit         rand_delay   = 1'b0;
    int         withhold_idx = 0;
    int         late_idx     = 0;
    int         start_count  = 0;
    int         extra_total  = 0;
    logic [5:0] op_log[$];
    logic [5:0] exp_sched[$];
    logic [7:0]   sbox_t [256];
    logic [127:0] rk [0:10];

    task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [7:0] xt(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p = 8'h00;
        logic [7:0] x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = xt(x);
        end
        return p;
    endfunction

    task automatic build_sbox();
        logic [7:0] inv;
        for (int v = 0; v < 256; v++) begin
            inv = 8'h00;
            if (v != 0) begin
                inv = 8'h01;
                for (int i = 0; i < 254; i++) inv = gmul(inv, 8'(v));
            end
            sbox_t[v] = inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]}
                            ^ {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
        end
    endtask

    task automatic expand_key(input logic [127:0] key);
        logic [31:0] w [0:43];
        logic [31:0] t;
        logic [7:0]  rc = 8'h01;
        for (int i = 0; i < 4; i++) w[i] = key[127-32*i -: 32];
        for (int i = 4; i < 44; i++) begin
            t = w[i-1];
            if (i % 4 == 0) begin
                t  = {t[23:0], t[31:24]};
                t  = {sbox_t[t[31:24]], sbox_t[t[23:16]], sbox_t[t[15:8]], sbox_t[t[7:0]]} ^ {rc, 24'h0};
                rc = xt(rc);
            end
            w[i] = w[i-4] ^ t;
        end
        for (int r = 0; r < 11; r++) rk[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
    endtask

    // One real AES transformation on a column-major state (byte 0 = bits 127:120).
    function automatic logic [127:0] aes_step(input logic [127:0] s, input logic [1:0] op, input logic [3:0] rnd);
        logic [7:0]   a [16];
        logic [7:0]   b [16];
        logic [127:0] o;
        if (op == 2'd0) return s ^ rk[rnd];
        for (int i = 0; i < 16; i++) a[i] = s[127-8*i -: 8];
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) begin
                if (op == 2'd1)      b[r+4*c] = sbox_t[a[r+4*c]];
                else if (op == 2'd2) b[r+4*c] = a[r+4*((c+r)%4)];
            end
            if (op == 2'd3) begin
                b[4*c]   = xt(a[4*c]) ^ xt(a[4*c+1]) ^ a[4*c+1] ^ a[4*c+2] ^ a[4*c+3];
                b[4*c+1] = a[4*c] ^ xt(a[4*c+1]) ^ xt(a[4*c+2]) ^ a[4*c+2] ^ a[4*c+3];
                b[4*c+2] = a[4*c] ^ a[4*c+1] ^ xt(a[4*c+2]) ^ xt(a[4*c+3]) ^ a[4*c+3];
                b[4*c+3] = xt(a[4*c]) ^ a[4*c] ^ a[4*c+1] ^ a[4*c+2] ^ xt(a[4*c+3]);
            end
        end
        for (int i = 0; i < 16; i++) o[127-8*i -: 8] = b[i];
        return o;
    endfunction

    function automatic logic [127:0] apply_op(input logic [127:0] s, input logic [1:0] op, input logic [3:0] rnd);
        if (aes_mode) return aes_step(s, op, rnd);
        return s ^ {16{{2'b00, op, rnd}}};
    endfunction

    // Reference: apply the first n_ops entries of the schedule to the plaintext.
    function automatic logic [127:0] model(input logic [127:0] pt, input int n_ops);
        logic [127:0] s = pt;
        logic [5:0]   e;
        for (int k = 0; k < n_ops; k++) begin
            e = exp_sched[k];
            s = apply_op(s, e[5:4], e[3:0]);
        end
        return s;
    endfunction

    // Stub round unit, reacting on the falling edge.
    initial begin : stub
        int  cnt    = 0;
        bit  active = 1'b0;
        bus.step_finish = 1'b0;
        bus.step_result = '0;
        forever begin
            @(negedge clk);
            bus.step_finish = 1'b0;
            if (!rst) begin
                active = 1'b0;
            end else if (bus.step_start) begin
                start_count++;
                op_log.push_back({bus.step_op, bus.step_round});
                active = (start_count != withhold_idx);
                cnt    = (start_count == late_idx) ? 3 : (rand_delay ? int'($urandom_range(0, 2)) : 0);
                if (active) extra_total += cnt;
            end else if (active) begin
                if (cnt == 0) begin
                    bus.step_finish = 1'b1;
                    bus.step_result = apply_op(bus.step_state, bus.step_op, bus.step_round);
                    active = 1'b0;
                end else begin
                    cnt--;
                end
            end
        end
    end

    task automatic start_pass(input logic [127:0] pt);
        for (int i = 0; i < 200 && !bus.in_ready; i++) @(negedge clk);
        start_count = 0;
        extra_total = 0;
        op_log.delete();
        bus.in_valid = 1'b1;
        bus.in_block = pt;
        @(negedge clk);
        bus.in_valid = 1'b0;
    endtask

    // cycles counts the acceptance edge as cycle 1.
    task automatic wait_valid(output int cycles);
        cycles = 1;
        while (!bus.out_valid && cycles < 400) begin
            @(negedge clk);
            cycles++;
        end
    endtask

    task automatic check_pass(input string tag, input logic [127:0] pt, input int cyc);
        int bad = 0;
        check_eq({tag, "_valid"}, bus.out_valid, 1'b1);
        check_eq({tag, "_err"}, bus.out_err, 1'b0);
        check_eq({tag, "_blk"}, bus.out_block, model(pt, 40));
        check_eq({tag, "_lat"}, cyc, 81 + extra_total);
        check_eq({tag, "_nops"}, op_log.size(), 40);
        for (int k = 0; k < op_log.size() && k < 40; k++)
            if (op_log[k] !== exp_sched[k]) bad++;
        check_eq({tag, "_sched"}, bad, 0);
    endtask

    task automatic release_out(input string tag);
        bus.out_ready = 1'b1;
        @(negedge clk);
        bus.out_ready = 1'b0;
        check_eq({tag, "_idle_rdy"}, bus.in_ready, 1'b1);
        check_eq({tag, "_idle_vld"}, bus.out_valid, 1'b0);
        check_eq({tag, "_idle_err"}, bus.out_err, 1'b0);
    endtask

    task automatic check_reset_outputs(input string tag);
        check_eq({tag, "_in_ready"}, bus.in_ready, 1'b1);
        check_eq({tag, "_out_valid"}, bus.out_valid, 1'b0);
        check_eq({tag, "_out_err"}, bus.out_err, 1'b0);
        check_eq({tag, "_busy"}, busy, 1'b0);
        check_eq({tag, "_start"}, bus.step_start, 1'b0);
        check_eq({tag, "_op"}, bus.step_op, 2'd0);
        check_eq({tag, "_round"}, bus.step_round, 4'd0);
        check_eq({tag, "_state"}, bus.step_state, 128'h0);
    endtask

    initial begin : watchdog
        #500000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin : main
        logic [127:0] pt, pt2, held;
        int  cyc;
        bit  found;

        bus.in_valid  = 1'b0;
        bus.in_block  = '0;
        bus.out_ready = 1'b0;
        build_sbox();
        expand_key(128'h000102030405060708090a0b0c0d0e0f);

        // Schedule straight from the round structure: AK0, 9x(SB SR MC AK), SB SR AK.
        exp_sched.push_back({2'd0, 4'd0});
        for (int r = 1; r < 10; r++) begin
            exp_sched.push_back({2'd1, 4'(r)});
            exp_sched.push_back({2'd2, 4'(r)});
            exp_sched.push_back({2'd3, 4'(r)});
            exp_sched.push_back({2'd0, 4'(r)});
        end
        exp_sched.push_back({2'd1, 4'd10});
        exp_sched.push_back({2'd2, 4'd10});
        exp_sched.push_back({2'd0, 4'd10});

        repeat (3) @(negedge clk);
        check_reset_outputs("rst");
        rst = 1'b1;
        @(negedge clk);

        // Zero plaintext, immediate finish: 81-cycle latency
        start_pass(128'h0);
        wait_valid(cyc);
        check_eq("zero_lat81", cyc, 81);
        check_pass("zero", 128'h0, cyc);
        release_out("zero");

        // Random plaintexts with random unit delays
        rand_delay = 1'b1;
        for (int n = 0; n < 4; n++) begin
            pt = {$urandom, $urandom, $urandom, $urandom};
            start_pass(pt);
            wait_valid(cyc);
            check_pass("rand", pt, cyc);
            release_out("rand");
        end

        // FIPS-197 C.1 with a real round unit
        aes_mode = 1'b1;
        pt = 128'h00112233445566778899aabbccddeeff;
        start_pass(pt);
        wait_valid(cyc);
        check_eq("fips_blk", bus.out_block, 128'h69c4e0d86a7b0430d8cdb78070b4c55a);
        check_eq("fips_err", bus.out_err, 1'b0);
        release_out("fips");
        aes_mode   = 1'b0;
        rand_delay = 1'b0;

        // Unit never finishes op #7: abort after 4 WAIT cycles with state after op #6
        withhold_idx = 7;
        pt = {$urandom, $urandom, $urandom, $urandom};
        start_pass(pt);
        wait_valid(cyc);
        check_eq("to_valid", bus.out_valid, 1'b1);
        check_eq("to_err", bus.out_err, 1'b1);
        check_eq("to_blk", bus.out_block, model(pt, 6));
        check_eq("to_lat", cyc, 1 + 2*6 + 1 + 4);
        check_eq("to_nops", op_log.size(), 7);
        release_out("to");
        withhold_idx = 0;

        // Finish on exactly the watchdog limit cycle: no error
        late_idx = 5;
        pt = {$urandom, $urandom, $urandom, $urandom};
        start_pass(pt);
        wait_valid(cyc);
        check_eq("late_lat", cyc, 84);
        check_pass("late", pt, cyc);
        release_out("late");
        late_idx = 0;

        // Hold out_ready low 10 cycles while a new block is offered
        pt  = {$urandom, $urandom, $urandom, $urandom};
        pt2 = {$urandom, $urandom, $urandom, $urandom};
        start_pass(pt);
        wait_valid(cyc);
        check_pass("bp", pt, cyc);
        held = model(pt, 40);
        bus.in_valid = 1'b1;
        bus.in_block = pt2;
        for (int i = 0; i < 10; i++) begin
            check_eq("bp_hold_vld", bus.out_valid, 1'b1);
            check_eq("bp_hold_blk", bus.out_block, held);
            check_eq("bp_hold_rdy", bus.in_ready, 1'b0);
            @(negedge clk);
        end
        bus.out_ready = 1'b1;
        @(negedge clk);
        bus.out_ready = 1'b0;
        check_eq("bp_after_rdy", bus.in_ready, 1'b1);
        check_eq("bp_after_vld", bus.out_valid, 1'b0);
        start_count = 0;
        extra_total = 0;
        op_log.delete();
        @(negedge clk);
        bus.in_valid = 1'b0;
        check_eq("bp_accept_busy", busy, 1'b1);
        wait_valid(cyc);
        check_pass("bp_next", pt2, cyc);
        release_out("bp_next");

        // Reset during WAIT of round 5, then a fresh pass
        rand_delay = 1'b1;
        pt = {$urandom, $urandom, $urandom, $urandom};
        start_pass(pt);
        found = 1'b0;
        for (int i = 0; i < 400 && !found; i++) begin
            if (bus.step_round == 4'd5 && busy && !bus.step_start && !bus.out_valid) found = 1'b1;
            else @(negedge clk);
        end
        check_eq("mid_reached_r5", found, 1'b1);
        #2 rst = 1'b0;
        #1 check_reset_outputs("mid_rst");
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        pt = {$urandom, $urandom, $urandom, $urandom};
        start_pass(pt);
        wait_valid(cyc);
        check_pass("post_rst", pt, cyc);
        release_out("post_rst");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
